// File: rtl/fetch_instr_queue.sv
// Instruction queue between fetch/realign and decode: DEPTH-entry in-order FIFO
// with a hold state that blocks further fetches after a faulting entry is accepted.
module fetch_instr_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [63:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic             is_compressed_i,
    input  logic             ex_valid_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [63:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic             is_compressed_o,
    output logic             ex_valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        RUN,
        EX_HOLD
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        is_compressed;
        logic        ex_valid;
    } entry_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    entry_t             head;
    logic               push, pop;

    always_comb begin
        ready_o = (count_q != CNT_W'(DEPTH)) && (state_q == RUN) && !flush_i;
        valid_o = (count_q != '0);
        push    = valid_i && ready_o;
        pop     = valid_o && ready_i;
    end

    // Upper half of a compressed instruction is never stored, so decode sees zeros.
    always_comb begin
        wr_entry.pc            = pc_i;
        wr_entry.instr         = is_compressed_i ? {16'h0, instr_i[15:0]} : instr_i;
        wr_entry.is_compressed = is_compressed_i;
        wr_entry.ex_valid      = ex_valid_i;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush_i) begin
            state_d = RUN;
            count_d = '0;
        end else begin
            if (state_q == RUN && push && ex_valid_i) begin
                state_d = EX_HOLD;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head            = mem_q[rd_ptr_q];
        pc_o            = valid_o ? head.pc            : '0;
        instr_o         = valid_o ? head.instr         : '0;
        is_compressed_o = valid_o ? head.is_compressed : 1'b0;
        ex_valid_o      = valid_o ? head.ex_valid      : 1'b0;
        count_o         = count_q;
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: queue-based reference model on the rising
// edge, monitor on the falling edge pops expected entries on each decoder handshake.
module tb_fetch_instr_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_i, flush_i, valid_i, ready_o;
    logic [63:0]      pc_i;
    logic [31:0]      instr_i;
    logic             is_compressed_i, ex_valid_i;
    logic             valid_o, ready_i;
    logic [63:0]      pc_o;
    logic [31:0]      instr_o;
    logic             is_compressed_o, ex_valid_o;
    logic [CNT_W-1:0] count_o;

    fetch_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .pc_i           (pc_i),
        .instr_i        (instr_i),
        .is_compressed_i(is_compressed_i),
        .ex_valid_i     (ex_valid_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .is_compressed_o(is_compressed_o),
        .ex_valid_o     (ex_valid_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        c;
        logic        ex;
    } exp_t;

    exp_t exp_q[$];
    int   mcount   = 0;
    bit   hold     = 0;
    bit   checking = 0;
    int   errors   = 0;
    int   checks   = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: occupancy, hold flag and stored entries advance on each rising edge.
    always @(posedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            mcount   = 0;
            hold     = 0;
            checking = 1;
        end else if (checking) begin
            if (flush_i) begin
                exp_q.delete();
                mcount = 0;
                hold   = 0;
            end else begin
                bit acc, deq;
                exp_t e;
                acc = valid_i && (mcount < DEPTH) && !hold;
                deq = (mcount != 0) && ready_i;
                if (acc) begin
                    e.pc    = pc_i;
                    e.instr = is_compressed_i ? {16'h0, instr_i[15:0]} : instr_i;
                    e.c     = is_compressed_i;
                    e.ex    = ex_valid_i;
                    exp_q.push_back(e);
                    if (ex_valid_i) hold = 1;
                end
                mcount = mcount + int'(acc) - int'(deq);
            end
        end
    end

    // Monitor: checks handshake/occupancy, then pops and compares on every decoder consume.
    always @(negedge clk) begin
        if (checking) begin
            exp_t e;
            cmp("valid_o", 64'(valid_o), 64'(mcount != 0));
            cmp("count_o", 64'(count_o), 64'(mcount));
            cmp("ready_o", 64'(ready_o), 64'((mcount < DEPTH) && !hold && !flush_i));
            if (!valid_o) begin
                cmp("idle_data", {pc_o ^ {32'h0, instr_o}, 62'h0, is_compressed_o, ex_valid_o} == '0 ? 64'(0) : 64'(1), 64'(0));
            end else if (ready_i) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    cmp("pc_o", pc_o, e.pc);
                    cmp("instr_o", 64'(instr_o), 64'(e.instr));
                    cmp("is_compressed_o", 64'(is_compressed_o), 64'(e.c));
                    cmp("ex_valid_o", 64'(ex_valid_o), 64'(e.ex));
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                       input bit c, input bit ex, input bit rdy, input bit fl, input bit rs);
        valid_i = v; pc_i = pc; instr_i = ins; is_compressed_i = c; ex_valid_i = ex;
        ready_i = rdy; flush_i = fl; rst_i = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 64'h0, 32'h0, 0, 0, rdy, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Single entry, one-cycle latency
        cyc(1, 64'h8000_0000, 32'h0000_0033, 0, 0, 1, 0, 0);
        idle(1); idle(1); idle(1);

        // Fill, rejected push while full with pop, then drain across the pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 64'h100 + 64'(4 * i), 32'h13 + 32'(i), 0, 0, 0, 0, 0);
        cyc(1, 64'h999, 32'hDEAD_BEEF, 0, 0, 1, 0, 0);
        cyc(1, 64'h110, 32'h0000_0113, 0, 0, 1, 0, 0);
        cyc(1, 64'h114, 32'h0000_0117, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) idle(1);

        // Compressed store masks the upper half
        cyc(1, 64'h180, 32'hFFFF_4501, 1, 0, 1, 0, 0);
        idle(1); idle(1);

        // Exception hold until flush
        cyc(1, 64'h200, 32'h0000_0073, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 64'h204 + 64'(4 * i), 32'h13, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 64'h210, 32'h13, 0, 0, 1, 0, 0);
        cyc(1, 64'h214, 32'h13, 0, 0, 1, 1, 0);
        cyc(1, 64'h218, 32'h0000_0093, 0, 0, 1, 0, 0);
        idle(1); idle(1);

        // Flush with 3 entries and a same-cycle input
        for (int i = 0; i < 3; i++) cyc(1, 64'h300 + 64'(4 * i), 32'h33, 0, 0, 0, 0, 0);
        cyc(1, 64'h30C, 32'h33, 0, 0, 0, 1, 0);
        idle(0); idle(1);

        // Reset with 2 entries while in hold
        cyc(1, 64'h400, 32'h33, 0, 0, 0, 0, 0);
        cyc(1, 64'h404, 32'h33, 0, 1, 0, 0, 0);
        cyc(1, 64'h408, 32'h33, 0, 0, 0, 0, 1);
        idle(0); idle(1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
        end
        idle(1); idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
Instruction queue between the fetch/realign stage and the decoder. Buffers up to DEPTH fetched instructions with their PC, compressed flag and fetch-exception flag, and presents them in order to the decoder over a valid/ready handshake. Flush support covers branch mispredicts and exceptions. After a faulting fetch is accepted, further fetches are blocked until flush.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  discard all entries and clear hold state
valid_i  input  1  upstream entry valid
ready_o  output  1  queue accepts an entry this cycle
pc_i  input  64  PC of incoming instruction
instr_i  input  32  instruction; only [15:0] meaningful when compressed
is_compressed_i  input  1  incoming instruction is 16-bit
ex_valid_i  input  1  fetch exception on incoming entry
valid_o  output  1  head entry valid toward decoder
ready_i  input  1  decoder consumes head this cycle
pc_o  output  64  head PC
instr_o  output  32  head instruction
is_compressed_o  output  1  head compressed flag
ex_valid_o  output  1  head exception flag
count_o  output  CNT_W  current occupancy

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset state: count=0, rd_ptr=wr_ptr=0, state=RUN.
  - Outputs after reset: valid_o=0, ready_o=1, count_o=0, pc_o/instr_o/is_compressed_o/ex_valid_o=0.
  - Storage is not cleared; data outputs are forced to 0 whenever valid_o=0.
- Push: push = valid_i & ready_o.
  - ready_o = (count != DEPTH) & (state==RUN) & !flush_i.
  - A full queue never accepts, even if a pop occurs in the same cycle.
- Pop: pop = valid_o & ready_i; valid_o = (count != 0).
  - Head fields are read combinationally from storage[rd_ptr].
- Latency: an entry pushed in cycle N is visible on valid_o in cycle N+1. There is no bypass.
- Store rule: when is_compressed_i=1, instr[31:16] is stored as 16'h0. Otherwise all 32 bits are stored unchanged.
- Pointers: log2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
- Count update:
  - push & pop: unchanged.
  - push only: +1.
  - pop only: -1.
- State machine:
  - RUN -> EX_HOLD when push & ex_valid_i. The faulting entry itself is stored.
  - In EX_HOLD: ready_o=0, and popping continues normally.
  - EX_HOLD -> RUN only on flush_i (or rst_i).
- Flush: flush_i=1 in cycle N means:
  - in N+1: count=0, rd_ptr=wr_ptr=0, state=RUN, valid_o=0;
  - in N: ready_o=0, so no push occurs;
  - a pop in cycle N still counts as a handshake but has no lasting effect.
- Precedence: rst_i > flush_i > push/pop.
- Reset or flush mid-stream discards all entries. Nothing is replayed.
- Never assert: count_o > DEPTH; valid_o with count=0; push while in EX_HOLD.

Test Plan:
- Reset, then push one entry (pc=64'h8000_0000, instr=32'h0000_0033) in cycle 1, ready_i=1 -> valid_o=1 in cycle 2 with those values; count_o=1 in cycle 2 and 0 in cycle 3.
- Fill and wrap: ready_i=0, push 4 entries (pc=0x100..0x10C) -> after 4th, count_o=4, ready_o=0.
  - A 5th push with simultaneous pop is rejected.
  - Then drain with ready_i=1 and push 2 more (pc=0x110, 0x114) -> pop order is 0x100..0x114 with no loss across the pointer wrap.
- Compressed: push instr_i=32'hFFFF_4501, is_compressed_i=1 -> instr_o=32'h0000_4501, is_compressed_o=1.
- Exception hold: push pc=0x200 with ex_valid_i=1 -> ready_o=0 next cycle while valid_i stays 1.
  - Head pops with ex_valid_o=1, and ready_o stays 0 afterwards.
  - flush_i for one cycle -> ready_o=1 the following cycle.
- Flush with 3 entries, valid_i=1 in the same cycle -> next cycle count_o=0, valid_o=0, and the same-cycle input is not stored.
- rst_i asserted with 2 entries and state=EX_HOLD -> next cycle count_o=0, valid_o=0, ready_o=1, all data outputs 0.
